display_sel_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 16 +
 rtl/seg7_scan.sv | 35 +++
 rtl/display_sel_scan.sv | 75 +++++++
 tb/tb_display_sel_scan.sv | 122 ++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared helpers for the display selector (hex decode, counter widths).
package disp_pkg;
  localparam int DIGITS = 32 / 4;
  localparam logic [6:0] HEX7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [6:0] hex7(input logic [3:0] n);
    return HEX7[n];
  endfunction
endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed active-low hex display driver, digit 0 = LS nibble.
module seg7_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     val,
  input  logic                  valid,
  output logic [DATA_W/4-1:0]   an,
  output logic [6:0]            seg
);
  localparam int NDIG = DATA_W / 4;
  localparam int CW = clog2w(SCAN_DIV);
  localparam int PW = clog2w(NDIG);
  logic [CW-1:0] scan_cnt;
  logic [PW-1:0] dig_ptr;
  logic wrap;
  assign wrap = scan_cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_ptr  <= '0;
      an       <= ~NDIG'(1);
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      if (wrap) dig_ptr <= (dig_ptr == PW'(NDIG - 1)) ? '0 : dig_ptr + 1'b1;
      an  <= valid ? ~(NDIG'(1) << dig_ptr) : '1;
      seg <= hex7(val[dig_ptr*4 +: 4]);
    end
  end
endmodule

// File: rtl/display_sel_scan.sv
// display_sel_scan: debounced/auto-rotating channel selector driving LEDs, a
// registered value output and a scanned hex display.
module display_sel_scan
  import disp_pkg::*;
#(
  parameter int N_CH     = 7,
  parameter int SEL_W    = 3,
  parameter int DATA_W   = 32,
  parameter int DEB_CYC  = 16,
  parameter int DWELL    = 50000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sw,
  input  logic                     auto_en,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_onehot,
  output logic [SEL_W-1:0]         ch_idx,
  output logic                     valid,
  output logic [DATA_W-1:0]        disp_val,
  output logic [DATA_W/4-1:0]      an,
  output logic [6:0]               seg
);
  localparam int DW = clog2w(DWELL);
  localparam int BW = clog2w(DEB_CYC);
  logic a1, auto_s, auto_q;
  logic [SEL_W-1:0] cand, stable;
  logic [BW-1:0] deb_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [DATA_W-1:0] sel_data;
  always_comb begin
    ch_onehot = '0;
    sel_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_onehot[k] = ch_idx == SEL_W'(k);
      if (ch_idx == SEL_W'(k)) sel_data = ch_data[k*DATA_W +: DATA_W];
    end
  end
  assign valid = |ch_onehot;
  always_ff @(posedge clk) begin
    if (rst) begin
      {auto_s, a1, auto_q} <= '0;
      cand      <= '0;
      deb_cnt   <= '0;
      stable    <= '0;
      ch_idx    <= '0;
      dwell_cnt <= '0;
      disp_val  <= '0;
    end else begin
      {auto_s, a1} <= {a1, auto_en};
      auto_q       <= auto_s;
      if (sw != cand) begin
        cand    <= sw;
        deb_cnt <= '0;
      end else if (deb_cnt == BW'(DEB_CYC - 1)) stable <= cand;
      else deb_cnt <= deb_cnt + 1'b1;
      // auto entry keeps a valid channel so rotation starts where the user was
      if (!auto_s) begin
        ch_idx    <= stable;
        dwell_cnt <= '0;
      end else if (!auto_q) begin
        dwell_cnt <= '0;
        ch_idx    <= valid ? ch_idx : '0;
      end else if (dwell_cnt == DW'(DWELL - 1)) begin
        dwell_cnt <= '0;
        ch_idx    <= (ch_idx == SEL_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
      end else dwell_cnt <= dwell_cnt + 1'b1;
      disp_val <= sel_data;
    end
  end
  seg7_scan #(.SCAN_DIV(SCAN_DIV), .DATA_W(DATA_W)) u_scan (
    .clk(clk), .rst(rst), .val(disp_val), .valid(valid), .an(an), .seg(seg)
  );
endmodule

// File: tb/tb_display_sel_scan.sv
// tb_display_sel_scan: directed + random stimulus against an edge-count reference model.
module tb_display_sel_scan;
  localparam int N_CH = 7, SEL_W = 3, DATA_W = 16, DEB = 4, DWELL = 8, SD = 2, NDIG = 4;
  logic clk = 0, rst = 1, auto_en = 0;
  logic [SEL_W-1:0] sw = 0;
  logic [15:0] d [N_CH];
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0] ch_onehot;
  logic [SEL_W-1:0] ch_idx;
  logic valid;
  logic [DATA_W-1:0] disp_val;
  logic [NDIG-1:0] an;
  logic [6:0] seg;
  logic [6:0] hx [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  int checks = 0, errors = 0;
  int m_last, m_run, m_stable, m_idx, m_disp, m_n, m_an, m_seg, m_base, m_k;
  bit h0, h1, m_prev;

  always #5 clk = ~clk;
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = d[k];
  end

  display_sel_scan #(.N_CH(N_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .DEB_CYC(DEB),
                     .DWELL(DWELL), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .sw(sw), .auto_en(auto_en), .ch_data(ch_data),
    .ch_onehot(ch_onehot), .ch_idx(ch_idx), .valid(valid), .disp_val(disp_val),
    .an(an), .seg(seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sw is accepted once it has been sampled identically on DEB+1 edges in a row;
  // auto mode index is base + (edges since entry)/DWELL modulo N_CH.
  task automatic model();
    int ip, dp, gp, st_pre;
    bit sp, vp;
    if (rst) begin
      m_last = 0; m_run = 1; m_stable = 0; m_idx = 0; m_disp = 0; m_n = 0;
      m_an = 4'he; m_seg = 7'h40; h0 = 0; h1 = 0; m_prev = 0;
      return;
    end
    sp = h1; h1 = h0; h0 = auto_en;
    ip = m_idx; vp = ip < N_CH; dp = m_disp; gp = (m_n / SD) % NDIG; st_pre = m_stable;
    if (int'(sw) == m_last) m_run++;
    else begin m_last = int'(sw); m_run = 1; end
    if (m_run > DEB) m_stable = m_last;
    if (!sp) m_idx = st_pre;
    else if (!m_prev) begin m_base = vp ? ip : 0; m_k = 0; m_idx = m_base; end
    else begin m_k++; m_idx = (m_base + m_k / DWELL) % N_CH; end
    m_prev = sp;
    m_disp = vp ? int'(d[ip]) : 0;
    m_an = vp ? (~(1 << gp)) & 15 : 15;
    m_seg = int'(hx[(dp >> (4 * gp)) & 15]);
    m_n++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("ch_idx", 32'(ch_idx), m_idx);
    chk("ch_onehot", 32'(ch_onehot), (m_idx < N_CH) ? (1 << m_idx) : 0);
    chk("valid", 32'(valid), 32'(m_idx < N_CH));
    chk("disp_val", 32'(disp_val), m_disp);
    chk("an", 32'(an), m_an);
    chk("seg", 32'(seg), m_seg);
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) d[k] = 16'(16'h1110 * k + k);
    repeat (2) cyc();
    chk("rst_onehot", 32'(ch_onehot), 1);
    chk("rst_disp", 32'(disp_val), 0);
    rst = 0;
    cyc();
    chk("first_an", 32'(an), 4'b1110);
    chk("first_seg", 32'(seg), 7'b1000000);
    sw = 2; repeat (8) cyc();
    chk("sw2_idx", 32'(ch_idx), 2);
    chk("sw2_disp", 32'(disp_val), 16'h2222);
    sw = 5; repeat (3) cyc();
    sw = 2; repeat (6) cyc();
    chk("glitch_idx", 32'(ch_idx), 2);
    sw = 6; repeat (8) cyc();
    chk("sw6_disp", 32'(disp_val), 16'h6666);
    sw = 7; repeat (8) cyc();
    chk("inv_valid", 32'(valid), 0);
    chk("inv_onehot", 32'(ch_onehot), 0);
    chk("inv_an", 32'(an), 4'b1111);
    sw = 5; repeat (8) cyc();
    auto_en = 1; repeat (40) cyc();
    auto_en = 0; repeat (4) cyc();
    sw = 3; repeat (18) cyc();
    chk("d3_seg", 32'(seg), 7'b0110000);
    d[3] = 16'habcd; repeat (12) cyc();
    sw = 1; auto_en = 1; repeat (12) cyc();
    sw = 4; repeat (2) cyc();
    rst = 1; cyc();
    chk("mid_rst_idx", 32'(ch_idx), 0);
    chk("mid_rst_an", 32'(an), 4'b1110);
    chk("mid_rst_seg", 32'(seg), 7'b1000000);
    rst = 0; auto_en = 0; repeat (8) cyc();
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, N_CH - 1)] = 16'($urandom);
      rst = $urandom_range(0, 149) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
